// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module  : ram_arb_pkg
// Purpose : Shared types and defaults for the two-port RAM arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  localparam int AW_DEF     = 8;
  localparam int DW_DEF     = 32;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = $clog2(RD_LAT_MAX);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    RWAIT = 3'd3,
    TURN  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module  : rr_arbiter2
// Purpose : Two-way round-robin grant; ties go to the port that did not win last.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    if (en) begin
      case (req)
        2'b01:   gnt_id = 1'b0;
        2'b10:   gnt_id = 1'b1;
        2'b11:   gnt_id = ~last_gnt;
        default: gnt_id = 1'b0;
      endcase
      if (req != 2'b00) begin
        gnt = gnt_id ? 2'b10 : 2'b01;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module  : ram_arbiter
// Purpose : Arbitrates two req/ack masters onto a single-port RAM and owns its
//           bidirectional data bus (drive on write, release with turnaround).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd_en,
  output logic          ram_wr_en,
  inout  wire  [DW-1:0] ram_data_io,
  output logic          busy
);

  state_e             state_q, state_d;
  logic               last_gnt_q;
  logic               port_q;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DW-1:0]      rdata0_q, rdata1_q;
  logic [1:0]         w_gnt;
  logic               w_gnt_id;
  logic               w_grant;
  logic               w_gnt_we;
  logic               w_ack;
  logic               w_capture;

  rr_arbiter2 u_rr (
    .req      ({req1, req0}),
    .last_gnt (last_gnt_q),
    .en       (state_q == IDLE),
    .gnt      (w_gnt),
    .gnt_id   (w_gnt_id)
  );

  assign w_grant   = |w_gnt;
  assign w_gnt_we  = w_gnt_id ? we1 : we0;
  assign w_capture = (state_q == RWAIT) && (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_grant) state_d = w_gnt_we ? WRITE : READ;
      WRITE:   state_d = IDLE;
      READ:    state_d = RWAIT;
      RWAIT:   if (cnt_q == '0) state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_gnt resets to 1 so that port 0 wins the first simultaneous request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt_q <= 1'b1;
      port_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      if (w_grant) begin
        port_q     <= w_gnt_id;
        last_gnt_q <= w_gnt_id;
        addr_q     <= w_gnt_id ? addr1  : addr0;
        wdata_q    <= w_gnt_id ? wdata1 : wdata0;
      end
      if (state_q == READ) begin
        cnt_q <= CNT_W'(RD_LAT - 1);
      end else if (state_q == RWAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (w_capture) begin
        if (port_q) rdata1_q <= ram_data_io;
        else        rdata0_q <= ram_data_io;
      end
    end
  end

  // Bus is driven only in WRITE; TURN keeps it released after the RAM's read drive.
  assign ram_data_io = (state_q == WRITE) ? wdata_q : {DW{1'bz}};

  assign w_ack     = (state_q == WRITE) || (state_q == TURN);
  assign ack0      = w_ack & ~port_q;
  assign ack1      = w_ack &  port_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign ram_addr  = addr_q;
  assign ram_rd_en = (state_q == READ);
  assign ram_wr_en = (state_q == WRITE);
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module  : tb_ram_arbiter
// Purpose : Scoreboarded directed bench for ram_arbiter with a 1-cycle RAM model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

  // Pattern the RAM model places on the bus when the arbiter should be released.
  localparam logic [31:0] PROBE = 32'hA5A5_5A5A;

  typedef struct packed {
    logic        port;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, ram_rd_en, ram_wr_en, busy;
  logic [31:0] rdata0, rdata1;
  logic [7:0]  ram_addr;
  wire  [31:0] ram_data_io;

  logic [31:0] mem [0:255];
  logic        rd_drive = 1'b0;
  logic [31:0] rd_val = '0;
  logic        prev_wr = 1'b0;
  logic        prev_rd = 1'b0;

  exp_t q[$];
  exp_t m_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(8), .DW(32), .RD_LAT(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .ack0        (ack0),
    .ack1        (ack1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .ram_addr    (ram_addr),
    .ram_rd_en   (ram_rd_en),
    .ram_wr_en   (ram_wr_en),
    .ram_data_io (ram_data_io),
    .busy        (busy)
  );

  // RAM model: read data appears on the bus the cycle after rd_en is sampled.
  assign ram_data_io = ram_wr_en ? {32{1'bz}} : (rd_drive ? rd_val : PROBE);

  always @(posedge clk) begin
    rd_drive <= ram_rd_en;
    if (ram_rd_en) rd_val <= mem[ram_addr];
    if (ram_wr_en) mem[ram_addr] <= ram_data_io;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, want);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic want);
    chk(name, {31'b0, act}, {31'b0, want});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!(ack0 || ack1) && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!(ack0 || ack1)) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: actual=no ack within 30 cycles required=ack", name);
    end
  endtask

  task automatic do_txn(input logic port, input logic we, input logic [7:0] a,
                        input logic [31:0] d, input logic [31:0] rexp);
    q.push_back('{port, ~we, rexp});
    if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    wait_ack("txn_ack");
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Monitor: every ack pops the next expected completion from the scoreboard.
  always @(negedge clk) begin
    prev_wr <= ram_wr_en;
    prev_rd <= ram_rd_en;
    if (ram_rd_en && ram_wr_en) begin
      n_chk++; n_fail++;
      $display("FAIL strobe_excl: actual=rd_en&wr_en both 1 required=at most one");
    end
    if ((ram_wr_en && prev_wr) || (ram_rd_en && prev_rd)) begin
      n_chk++; n_fail++;
      $display("FAIL strobe_width: actual=strobe high 2 cycles required=1 cycle");
    end
    if (ack0 || ack1) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_ack: actual=ack0=%b ack1=%b required=no ack", ack0, ack1);
      end else begin
        m_e = q.pop_front();
        chk1("ack_port", ack1, m_e.port);
        chk1("ack_onehot", ack0 ^ ack1, 1'b1);
        if (m_e.rd) chk("ack_rdata", m_e.port ? rdata1 : rdata0, m_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_ack0", ack0, 1'b0);
    chk1("rst_ack1", ack1, 1'b0);
    chk1("rst_rd_en", ram_rd_en, 1'b0);
    chk1("rst_wr_en", ram_wr_en, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_addr", {24'b0, ram_addr}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_bus_z", ram_data_io, PROBE);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // Reset pulse while idle
    reset = 1'b1;
    #1;
    chk1("idle_rst_busy", busy, 1'b0);
    chk("idle_rst_bus_z", ram_data_io, PROBE);
    repeat (2) begin
      @(negedge clk);
      chk1("idle_rst_hold_busy", busy, 1'b0);
    end
    tick();
    reset = 1'b0;
    tick();

    // Port 0 write 255 = 99
    q.push_back('{1'b0, 1'b0, 32'd0});
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd255; wdata0 = 32'd99;
    tick();
    @(negedge clk);
    chk1("wr_en", ram_wr_en, 1'b1);
    chk1("wr_rd_en_low", ram_rd_en, 1'b0);
    chk("wr_addr", {24'b0, ram_addr}, 32'd255);
    chk("wr_bus", ram_data_io, 32'd99);
    chk1("wr_ack0", ack0, 1'b1);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    chk1("wr_one_cycle", ram_wr_en, 1'b0);
    chk1("wr_idle_busy", busy, 1'b0);

    // Port 1 read 255 -> 99
    tick();
    q.push_back('{1'b1, 1'b1, 32'd99});
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd255;
    tick();
    @(negedge clk);
    chk1("rd_en", ram_rd_en, 1'b1);
    chk("rd_addr", {24'b0, ram_addr}, 32'd255);
    chk("rd_bus_z", ram_data_io, PROBE);
    chk1("rd_no_ack", ack1, 1'b0);
    tick();
    @(negedge clk);
    chk1("rwait_rd_en", ram_rd_en, 1'b0);
    chk1("rwait_busy", busy, 1'b1);
    chk("rwait_bus_ram", ram_data_io, 32'd99);
    tick();
    @(negedge clk);
    chk1("rd_ack_latency", ack1, 1'b1);
    chk("turn_bus_z", ram_data_io, PROBE);
    tick();
    req1 = 1'b0;
    @(negedge clk);
    chk1("rd_idle_busy", busy, 1'b0);

    // Both ports requesting continuously: grants alternate starting with port 0
    tick();
    for (int k = 0; k < 4; k++) q.push_back('{k[0], 1'b0, 32'd0});
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd254; wdata0 = 32'h11;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'd253; wdata1 = 32'h22;
    for (int k = 0; k < 4; k++) begin
      wait_ack("rr_ack");
      chk("rr_addr", {24'b0, ram_addr}, k[0] ? 32'd253 : 32'd254);
      chk("rr_bus", ram_data_io, k[0] ? 32'h22 : 32'h11);
      tick();
      if (k == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end

    // Port 0 reads 254 while port 1 waits to write 254 = 77
    q.push_back('{1'b0, 1'b1, 32'h11});
    q.push_back('{1'b1, 1'b0, 32'd0});
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd254;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'd254; wdata1 = 32'd77;
    wait_ack("t5_read_ack");
    chk1("t5_port0_first", ack0, 1'b1);
    chk("t5_turn_bus_z", ram_data_io, PROBE);
    chk1("t5_turn_no_wr", ram_wr_en, 1'b0);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    chk1("t5_gap_no_wr", ram_wr_en, 1'b0);
    wait_ack("t5_write_ack");
    chk1("t5_wr_en", ram_wr_en, 1'b1);
    chk("t5_wr_addr", {24'b0, ram_addr}, 32'd254);
    chk("t5_wr_bus", ram_data_io, 32'd77);
    tick();
    req1 = 1'b0;
    do_txn(1'b0, 1'b0, 8'd254, 32'd0, 32'd77);

    // Reset during RWAIT aborts the read with no ack
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd255;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    req0 = 1'b0;
    chk1("abort_rd_en", ram_rd_en, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_no_ack", ack0, 1'b0);
    chk("abort_rdata1_clr", rdata1, 32'd0);
    tick();
    @(negedge clk);
    chk("abort_bus_z", ram_data_io, PROBE);
    chk1("abort_busy_hold", busy, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    do_txn(1'b0, 1'b1, 8'd255, 32'd5, 32'd0);
    do_txn(1'b1, 1'b0, 8'd255, 32'd0, 32'd5);

    repeat (5) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
